mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single external data/instruction SRAM between the IF stage (instruction fetch) and the MEM stage (load/store).
//  Sequences each SRAM access through a multi-cycle FSM and returns a one-cycle ready pulse to the granted requester.
//  Pipeline stages stall on their own request until ready; the hazard unit consumes busy_o.
// PARAMETERS
//  ADDRESS_WIDTH  16  width of all address buses
//  DATA_WIDTH     16  width of all data buses
//  WAIT_CYCLES    2   SRAM strobe cycles per access (>=1); counter width = $clog2(WAIT_CYCLES+1)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  if_req_i     in   1   IF fetch request, level, held until if_ready_o
//  if_addr_i    in   AW  fetch address (PC)
//  if_rdata_o   out  DW  fetched instruction, valid while if_ready_o
//  if_ready_o   out  1   one-cycle pulse: fetch complete
//  mem_read_i   in   1   MEM load request, level
//  mem_write_i  in   1   MEM store request, level (never together with mem_read_i)
//  mem_addr_i   in   AW  load/store address
//  mem_wdata_i  in   DW  store data
//  mem_rdata_o  out  DW  load data, valid while mem_ready_o
//  mem_ready_o  out  1   one-cycle pulse: load/store complete
//  busy_o       out  1   high in any state other than IDLE
//  ram_addr_o   out  AW  SRAM address
//  ram_wdata_o  out  DW  SRAM write data
//  ram_rdata_i  in   DW  SRAM read data
//  ram_ce_o     out  1   chip enable, active-high (pad inversion is done at top level)
//  ram_oe_o     out  1   output enable for reads, active-high
//  ram_we_o     out  1   write enable, active-high
// BEHAVIOUR
//  Reset (async): state=IDLE, grant=NONE, cnt=0; all ready/strobe outputs 0; rdata regs, ram_addr_o and ram_wdata_o = 0.
//  FSM states:
//   IDLE: if a MEM request is pending -> grant MEM; else if if_req_i -> grant IF; else stay.
//     On grant: latch addr, wdata and op (rd/wr); cnt<=WAIT_CYCLES-1; go to ACCESS.
//   ACCESS: ram_ce_o=1, ram_addr_o/ram_wdata_o from latches, ram_oe_o=rd, ram_we_o=wr.
//     cnt decrements each cycle. When cnt==0: capture ram_rdata_i (reads only) into the granted rdata reg; go to DONE.
//   DONE: all strobes 0 (write recovery). Pulse the granted requester's ready. Requests are ignored. Go to IDLE.
//  Latency: request seen in IDLE at cycle 0 -> ready high in cycle WAIT_CYCLES+1.
//   Back-to-back accesses occur every WAIT_CYCLES+2 cycles.
//  Requester rule: a request still high in the cycle after ready is a NEW access; IF relies on this for continuous fetch.
//  rdata registers hold their value until the next completed read for that port. A write does not alter mem_rdata_o.
//  Request changes during ACCESS/DONE have no effect on the access in flight; latched values are used.
//  Simultaneous IF and MEM requests in IDLE: arbitration per CONFIGURATION; the loser stays pending and is served next.
//  Reset mid-access: strobes drop immediately (async). The access is aborted with no ready pulse; a partial write is not retried.
//  mem_read_i & mem_write_i both high is illegal; the store wins (op=wr).
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//   - A last_grant flop (reset = IF) is added.
//   - On a simultaneous request, the requester not granted last wins.
//  ARB_ROUND_ROBIN_EN undefined: MEM always wins over IF (fixed priority); no last_grant flop.
//  Single-requester behaviour is identical in both builds.
// STRUCTURE
//  Shared header cpu_defs.vh holds:
//   - state encodings ST_IDLE/ST_ACCESS/ST_DONE
//   - grant codes GNT_NONE/GNT_IF/GNT_MEM
//   - op codes OP_RD/OP_WR
//  One sub-module, arb_pick: a combinational winner select from if_req, mem_req and last_grant, honouring ARB_ROUND_ROBIN_EN.
//  The FSM, counter and latches stay in mem_port_arbiter.
// TESTING (WAIT_CYCLES=2 unless stated)
//  1 Reset then if_req_i=1, if_addr_i=0x0010, ram_rdata_i=0xA5A5 -> ram_ce_o/ram_oe_o high cycles 1-2; if_ready_o high cycle 3 with if_rdata_o=0xA5A5.
//  2 mem_write_i=1, addr 0x8000, wdata 0x1234 -> ram_we_o high exactly 2 cycles with addr 0x8000 / data 0x1234; mem_ready_o pulse in cycle 3; mem_rdata_o unchanged.
//  3 if_req_i and mem_read_i rise in the same cycle, fixed priority -> MEM served first (ready cycle 3), IF served next (ready cycle 7).
//    With ARB_ROUND_ROBIN_EN and two consecutive collisions: grants go MEM then IF, and the third collision goes to MEM.
//  4 if_req_i held high continuously -> if_ready_o pulses every 4 cycles; busy_o low exactly one cycle between accesses.
//  5 rst asserted during ACCESS of a write -> ram_we_o/ram_ce_o drop in the same cycle; no ready pulse; the next request after reset restarts from IDLE.
//  6 WAIT_CYCLES=1, mem_read_i with ram_rdata_i=0xBEEF -> mem_ready_o high in cycle 2 with mem_rdata_o=0xBEEF.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter: FSM states, grant owners and access ops.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_MEM  = 2'd2
  } grant_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // A store wins if a load and a store are ever raised together.
  function automatic op_t mem_op(input logic wr);
    return wr ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select between IF and MEM; zero latency, no state.
// ARB_ROUND_ROBIN_EN: a collision goes to the requester not granted last; otherwise MEM always wins.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   mem_req,
  input  grant_t last_grant,
  output grant_t pick
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    pick = GNT_NONE;
    if (if_req && mem_req) begin
      pick = (last_grant == GNT_MEM) ? GNT_IF : GNT_MEM;
    end else if (mem_req) begin
      pick = GNT_MEM;
    end else if (if_req) begin
      pick = GNT_IF;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    pick = GNT_NONE;
    if (mem_req) begin
      pick = GNT_MEM;
    end else if (if_req) begin
      pick = GNT_IF;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM between IF fetch and MEM load/store; ready pulses WAIT_CYCLES+1 cycles after the grant.
// Requesters hold a level request until ready; ARB_ROUND_ROBIN_EN swaps MEM-first priority for round-robin.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req_i,
  input  logic [ADDRESS_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0]    if_rdata_o,
  output logic                     if_ready_o,
  input  logic                     mem_read_i,
  input  logic                     mem_write_i,
  input  logic [ADDRESS_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0]    mem_wdata_i,
  output logic [DATA_WIDTH-1:0]    mem_rdata_o,
  output logic                     mem_ready_o,
  output logic                     busy_o,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]    ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]    ram_rdata_i,
  output logic                     ram_ce_o,
  output logic                     ram_oe_o,
  output logic                     ram_we_o
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  state_t                   state_q, state_d;
  grant_t                   grant_q, grant_d;
  grant_t                   last_grant, pick;
  op_t                      op_q, op_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]    mem_rdata_q, mem_rdata_d;
  logic                     mem_req;

  assign mem_req = mem_read_i | mem_write_i;

  arb_pick u_arb_pick (
    .if_req     (if_req_i),
    .mem_req    (mem_req),
    .last_grant (last_grant),
    .pick       (pick)
  );

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GNT_IF;
    end else if (state_q == ST_IDLE && pick != GNT_NONE) begin
      last_grant <= pick;
    end
  end
`else
  assign last_grant = GNT_IF;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_NONE;
      op_q        <= OP_RD;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    ram_ce_o    = 1'b0;
    ram_oe_o    = 1'b0;
    ram_we_o    = 1'b0;
    if_ready_o  = 1'b0;
    mem_ready_o = 1'b0;
    busy_o      = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (pick != GNT_NONE) begin
          grant_d = pick;
          addr_d  = (pick == GNT_MEM) ? mem_addr_i : if_addr_i;
          wdata_d = mem_wdata_i;
          op_d    = (pick == GNT_MEM) ? mem_op(mem_write_i) : OP_RD;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ram_ce_o = 1'b1;
        ram_oe_o = (op_q == OP_RD);
        ram_we_o = (op_q == OP_WR);
        if (cnt_q == '0) begin
          if (op_q == OP_RD) begin
            if (grant_q == GNT_IF) begin
              if_rdata_d = ram_rdata_i;
            end else begin
              mem_rdata_d = ram_rdata_i;
            end
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        // Strobes stay low here to give the SRAM a write-recovery cycle.
        if_ready_o  = (grant_q == GNT_IF);
        mem_ready_o = (grant_q == GNT_MEM);
        grant_d     = GNT_NONE;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural SRAM plus a word-level memory model and per-scenario tasks.
module tb_mem_port_arbiter;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_ready_o;
  logic [15:0] if_addr_i, if_rdata_o;
  logic        mem_read_i, mem_write_i, mem_ready_o, busy_o;
  logic [15:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [15:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic        ram_ce_o, ram_oe_o, ram_we_o;

  logic        s_if_req, s_if_ready, s_mem_read, s_mem_write, s_mem_ready, s_busy;
  logic [15:0] s_if_addr, s_if_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [15:0] s_ram_addr, s_ram_wdata, s_ram_rdata;
  logic        s_ram_ce, s_ram_oe, s_ram_we;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_if_rdata, exp_mem_rdata;
  logic [15:0] sram [256];
  bit          sram_valid [256];
  logic [15:0] model_mem [256];
  bit          model_valid [256];
  logic        rd_ovr_en;
  logic [15:0] rd_ovr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ready_o(mem_ready_o),
    .busy_o(busy_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .ram_ce_o(ram_ce_o), .ram_oe_o(ram_oe_o), .ram_we_o(ram_we_o)
  );

  mem_port_arbiter #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req_i(s_if_req), .if_addr_i(s_if_addr), .if_rdata_o(s_if_rdata), .if_ready_o(s_if_ready),
    .mem_read_i(s_mem_read), .mem_write_i(s_mem_write), .mem_addr_i(s_mem_addr),
    .mem_wdata_i(s_mem_wdata), .mem_rdata_o(s_mem_rdata), .mem_ready_o(s_mem_ready),
    .busy_o(s_busy), .ram_addr_o(s_ram_addr), .ram_wdata_o(s_ram_wdata), .ram_rdata_i(s_ram_rdata),
    .ram_ce_o(s_ram_ce), .ram_oe_o(s_ram_oe), .ram_we_o(s_ram_we)
  );

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'd40503) ^ 16'h5A5A;
  endfunction

  // Behavioural SRAM: unwritten words read a fixed address hash.
  always @(posedge clk) begin
    if (ram_ce_o && ram_we_o) begin
      sram[ram_addr_o[7:0]]       <= ram_wdata_o;
      sram_valid[ram_addr_o[7:0]] <= 1'b1;
    end
  end

  assign ram_rdata_i = rd_ovr_en ? rd_ovr :
                       (sram_valid[ram_addr_o[7:0]] ? sram[ram_addr_o[7:0]] : init_val(ram_addr_o));

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    return model_valid[a[7:0]] ? model_mem[a[7:0]] : init_val(a);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    if_req_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_if_rdata  = 16'h0000;
    exp_mem_rdata = 16'h0000;
  endtask

  // One access from idle: strobes/address every ACCESS cycle, then the ready cycle with data.
  task automatic do_txn(input bit is_mem, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input string tag);
    logic [15:0] exp_rd;
    logic [2:0]  exp_stb;
    exp_rd  = rd_ovr_en ? rd_ovr : model_rd(a);
    exp_stb = {1'b1, !wr, wr};
    step();
    n_chk++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL %s_idle: busy_o=%b want 0", tag, busy_o); end
    if (is_mem) begin
      mem_addr_i = a; mem_wdata_i = d; mem_write_i = wr; mem_read_i = !wr;
    end else begin
      if_addr_i = a; if_req_i = 1'b1;
    end
    for (int c = 1; c <= W + 1; c++) begin
      step();
      if (c <= W) begin
        n_chk++;
        if ({ram_ce_o, ram_oe_o, ram_we_o} !== exp_stb) begin
          n_fail++; $display("FAIL %s_strobe c%0d: ce/oe/we=%b want %b", tag, c, {ram_ce_o, ram_oe_o, ram_we_o}, exp_stb);
        end
        n_chk++;
        if (ram_addr_o !== a) begin n_fail++; $display("FAIL %s_addr c%0d: %h want %h", tag, c, ram_addr_o, a); end
        if (wr) begin
          n_chk++;
          if (ram_wdata_o !== d) begin n_fail++; $display("FAIL %s_wdata c%0d: %h want %h", tag, c, ram_wdata_o, d); end
        end
        n_chk++;
        if ({if_ready_o, mem_ready_o} !== 2'b00) begin
          n_fail++; $display("FAIL %s_early_ready c%0d: %b want 00", tag, c, {if_ready_o, mem_ready_o});
        end
        if (c == 1) begin
          if (is_mem) begin mem_addr_i = 16'($urandom); mem_wdata_i = 16'($urandom); end
          else if_addr_i = 16'($urandom);
        end
      end else begin
        if (!is_mem) exp_if_rdata = exp_rd;
        else if (!wr) exp_mem_rdata = exp_rd;
        n_chk++;
        if ({ram_ce_o, ram_oe_o, ram_we_o} !== 3'b000) begin
          n_fail++; $display("FAIL %s_done_strobe: %b want 000", tag, {ram_ce_o, ram_oe_o, ram_we_o});
        end
        n_chk++;
        if ({if_ready_o, mem_ready_o} !== {!is_mem, is_mem}) begin
          n_fail++; $display("FAIL %s_ready: if/mem=%b want %b", tag, {if_ready_o, mem_ready_o}, {!is_mem, is_mem});
        end
        n_chk++;
        if (if_rdata_o !== exp_if_rdata) begin n_fail++; $display("FAIL %s_if_rdata: %h want %h", tag, if_rdata_o, exp_if_rdata); end
        n_chk++;
        if (mem_rdata_o !== exp_mem_rdata) begin n_fail++; $display("FAIL %s_mem_rdata: %h want %h", tag, mem_rdata_o, exp_mem_rdata); end
      end
    end
    drive_idle();
    if (wr) begin model_mem[a[7:0]] = d; model_valid[a[7:0]] = 1'b1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    step();
    n_chk++;
    if ({if_ready_o, mem_ready_o, busy_o, ram_ce_o, ram_oe_o, ram_we_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: %b want 000000", {if_ready_o, mem_ready_o, busy_o, ram_ce_o, ram_oe_o, ram_we_o});
    end
    n_chk++;
    if ({ram_addr_o, ram_wdata_o} !== 32'h0) begin n_fail++; $display("FAIL reset_ram_bus: %h want 0", {ram_addr_o, ram_wdata_o}); end
    n_chk++;
    if ({if_rdata_o, mem_rdata_o} !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: %h want 0", {if_rdata_o, mem_rdata_o}); end
    apply_reset();
  endtask

  task automatic test_fetch();
    rd_ovr_en = 1'b1; rd_ovr = 16'hA5A5;
    do_txn(1'b0, 1'b0, 16'h0010, 16'h0000, "fetch");
    rd_ovr_en = 1'b0;
  endtask

  task automatic test_store();
    do_txn(1'b1, 1'b1, 16'h8000, 16'h1234, "store");
  endtask

  task automatic test_random();
    logic [15:0] a;
    bit is_mem, wr;
    for (int i = 0; i < 40; i++) begin
      is_mem = 1'($urandom_range(0, 1));
      wr     = is_mem && ($urandom_range(0, 1) == 1);
      a      = {8'($urandom), 8'($urandom_range(0, 7))};
      do_txn(is_mem, wr, a, 16'($urandom), "rand");
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic test_collision();
    int t_if, t_mem;
    logic [15:0] e_if, e_mem;
    apply_reset();
    e_if = model_rd(16'h0020); e_mem = model_rd(16'h0031);
    t_if = -1; t_mem = -1;
    step();
    if_addr_i = 16'h0020; if_req_i = 1'b1; mem_addr_i = 16'h0031; mem_read_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (mem_ready_o === 1'b1) begin t_mem = c; mem_read_i = 1'b0; end
      if (if_ready_o === 1'b1) begin t_if = c; if_req_i = 1'b0; end
    end
    n_chk++;
    if (t_mem != 3) begin n_fail++; $display("FAIL coll_mem_cycle: %0d want 3", t_mem); end
    n_chk++;
    if (t_if != 7) begin n_fail++; $display("FAIL coll_if_cycle: %0d want 7", t_if); end
    n_chk++;
    if (mem_rdata_o !== e_mem) begin n_fail++; $display("FAIL coll_mem_rdata: %h want %h", mem_rdata_o, e_mem); end
    n_chk++;
    if (if_rdata_o !== e_if) begin n_fail++; $display("FAIL coll_if_rdata: %h want %h", if_rdata_o, e_if); end
    exp_if_rdata = e_if; exp_mem_rdata = e_mem;
  endtask

  // Both requesters held for four accesses; the winner list comes from the arbitration rule alone.
  task automatic test_contention();
    bit mem_win [4];
    bit last_mem, if_won;
    logic exp_i, exp_m;
    last_mem = 1'b0; if_won = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      mem_win[k] = !last_mem;
`else
      mem_win[k] = 1'b1;
`endif
      last_mem = mem_win[k];
      if (!mem_win[k]) if_won = 1'b1;
    end
    apply_reset();
    step();
    if_addr_i = 16'h0044; if_req_i = 1'b1; mem_addr_i = 16'h0055; mem_read_i = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      exp_i = (c % 4 == 3) && !mem_win[c / 4];
      exp_m = (c % 4 == 3) && mem_win[c / 4];
      n_chk++;
      if ({if_ready_o, mem_ready_o} !== {exp_i, exp_m}) begin
        n_fail++; $display("FAIL contend c%0d: if/mem ready=%b want %b", c, {if_ready_o, mem_ready_o}, {exp_i, exp_m});
      end
    end
    drive_idle();
    exp_mem_rdata = model_rd(16'h0055);
    if (if_won) exp_if_rdata = model_rd(16'h0044);
  endtask

  task automatic test_back_to_back();
    step();
    if_addr_i = 16'h0040; if_req_i = 1'b1;
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) step();
      n_chk++;
      if ({busy_o, if_ready_o} !== {c % 4 != 0, c % 4 == 3}) begin
        n_fail++; $display("FAIL b2b c%0d: busy/ready=%b want %b", c, {busy_o, if_ready_o}, {c % 4 != 0, c % 4 == 3});
      end
    end
    drive_idle();
    exp_if_rdata = model_rd(16'h0040);
    n_chk++;
    if (if_rdata_o !== exp_if_rdata) begin n_fail++; $display("FAIL b2b_rdata: %h want %h", if_rdata_o, exp_if_rdata); end
  endtask

  task automatic test_reset_mid();
    step();
    mem_addr_i = 16'h00F0; mem_wdata_i = 16'h5555; mem_write_i = 1'b1;
    step();
    n_chk++;
    if ({ram_ce_o, ram_we_o} !== 2'b11) begin n_fail++; $display("FAIL rstmid_pre: ce/we=%b want 11", {ram_ce_o, ram_we_o}); end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({ram_ce_o, ram_we_o, busy_o} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_drop: ce/we/busy=%b want 000", {ram_ce_o, ram_we_o, busy_o});
    end
    drive_idle();
    step();
    step();
    rst = 1'b0;
    exp_if_rdata = 16'h0000; exp_mem_rdata = 16'h0000;
    for (int c = 0; c < 4; c++) begin
      step();
      n_chk++;
      if ({mem_ready_o, if_ready_o, busy_o} !== 3'b000) begin
        n_fail++; $display("FAIL rstmid_quiet c%0d: %b want 000", c, {mem_ready_o, if_ready_o, busy_o});
      end
    end
    do_txn(1'b1, 1'b0, 16'h00F0, 16'h0000, "rstmid_after");
  endtask

  task automatic test_wait1();
    step();
    s_mem_addr = 16'h0077; s_mem_read = 1'b1;
    step();
    n_chk++;
    if ({s_ram_ce, s_ram_oe, s_ram_we, s_mem_ready} !== 4'b1100) begin
      n_fail++; $display("FAIL w1_access: ce/oe/we/ready=%b want 1100", {s_ram_ce, s_ram_oe, s_ram_we, s_mem_ready});
    end
    step();
    n_chk++;
    if ({s_ram_ce, s_mem_ready} !== 2'b01) begin n_fail++; $display("FAIL w1_ready: ce/ready=%b want 01", {s_ram_ce, s_mem_ready}); end
    n_chk++;
    if (s_mem_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL w1_rdata: %h want beef", s_mem_rdata); end
    s_mem_read = 1'b0;
    step();
    n_chk++;
    if (s_busy !== 1'b0) begin n_fail++; $display("FAIL w1_idle: busy=%b want 0", s_busy); end
  endtask

  initial begin
    rst = 1'b1;
    rd_ovr_en = 1'b0; rd_ovr = 16'h0000;
    if_req_i = 1'b0; if_addr_i = '0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    mem_addr_i = '0; mem_wdata_i = '0;
    s_if_req = 1'b0; s_if_addr = '0; s_mem_read = 1'b0; s_mem_write = 1'b0;
    s_mem_addr = '0; s_mem_wdata = '0; s_ram_rdata = 16'hBEEF;
    exp_if_rdata = '0; exp_mem_rdata = '0;
    test_reset();
    test_fetch();
    test_store();
    test_random();
    test_collision();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_wait1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
